// File: rtl/deser_word_arbiter_pkg.sv
// Shared definitions for the word-atomic round-robin deserializer arbiter:
// arbiter state encoding and a constant clog2 helper used to size index buses.
package deser_word_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Ceiling log2, usable in parameter and port width expressions.
    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        while ((32'sd1 <<< res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/deser_word_arbiter_rr_pick.sv
// Combinational round-robin priority picker: scans the request vector starting
// at start_i (wrapping modulo N) and reports the first set request.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] start_i,
    output logic [IDW-1:0] winner_o,
    output logic           found_o
);

    localparam int           IDW_P1 = IDW + 1;
    localparam logic [IDW:0] N_W    = IDW_P1'(N);

    logic [IDW:0] sum_s;
    logic [IDW:0] idx_s;

    // Walk the requesters in rotated order and keep the first one that is set.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int i = 0; i < N; i++) begin
            sum_s    = {1'b0, start_i} + IDW_P1'(i);
            idx_s    = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
            winner_o = (!found_o && req_i[idx_s[IDW-1:0]]) ? idx_s[IDW-1:0] : winner_o;
            found_o  = found_o | req_i[idx_s[IDW-1:0]];
        end
    end

endmodule

// File: rtl/deser_word_arbiter.sv
// Word-atomic round-robin arbiter placed directly upstream of one deserializer.
// A granted requester keeps ownership for exactly BEATS beat transfers so that
// every deserializer word comes from a single source. Beat handshakes pass
// through combinationally; ownership state is registered.
// Optional feature: define DESER_ARB_WDOG_EN to enable the mid-word stall
// watchdog (sticky wdog_err after WDOG_CYCLES stalled cycles).
module deser_word_arbiter
    import deser_word_arbiter_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int INLOGBITS   = 3,
    parameter int OUTLOGBITS  = 6,
    parameter int WDOG_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ*(1<<INLOGBITS)-1:0]       req_data,
    output logic                                 des_valid,
    input  logic                                 des_ready,
    output logic [(1<<INLOGBITS)-1:0]            des_data,
    output logic                                 grant_valid,
    output logic [clog2_f(NREQ)-1:0]             grant_id,
    output logic                                 wdog_err
);

    localparam int             INWIDTH  = 1 << INLOGBITS;
    localparam int             CW       = OUTLOGBITS - INLOGBITS;
    localparam int             BEATS    = 1 << CW;
    localparam int             IDW      = clog2_f(NREQ);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BEATS - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    arb_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [IDW-1:0] grant_id_q;
    logic [IDW-1:0] last_id_q;

    logic [IDW-1:0] start_s;
    logic [IDW-1:0] winner_s;
    logic           found_s;
    logic           xfer_s;
    logic           word_end_s;

    // Search begins just after the previous owner, which makes the current
    // owner the lowest priority when a word completes.
    assign start_s    = (last_id_q == LAST_RST) ? '0 : (last_id_q + ID_ONE);
    assign xfer_s     = des_valid & des_ready;
    assign word_end_s = (cnt_q == CNT_LAST);

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i    (req_valid),
        .start_i  (start_s),
        .winner_o (winner_s),
        .found_o  (found_s)
    );

    // Route the owner's beat handshake straight through; everyone else waits.
    always_comb begin
        req_ready = '0;
        des_valid = 1'b0;
        des_data  = '0;
        if (state_q == ST_BURST) begin
            des_valid             = req_valid[grant_id_q];
            des_data              = req_data[grant_id_q*INWIDTH +: INWIDTH];
            req_ready[grant_id_q] = des_ready;
        end else begin
            req_ready = '0;
            des_valid = 1'b0;
            des_data  = '0;
        end
    end

    // Ownership FSM: grant on any request, hold for a full word, re-arbitrate
    // on the last beat so back-to-back words have no idle bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_id_q <= '0;
            last_id_q  <= LAST_RST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        state_q    <= ST_BURST;
                        grant_id_q <= winner_s;
                        last_id_q  <= winner_s;
                        cnt_q      <= '0;
                    end
                end
                ST_BURST: begin
                    if (xfer_s) begin
                        if (word_end_s) begin
                            cnt_q <= '0;
                            if (found_s) begin
                                grant_id_q <= winner_s;
                                last_id_q  <= winner_s;
                            end else begin
                                state_q    <= ST_IDLE;
                                grant_id_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    grant_id_q <= '0;
                end
            endcase
        end
    end

    assign grant_valid = (state_q == ST_BURST);
    assign grant_id    = grant_id_q;

`ifdef DESER_ARB_WDOG_EN
    localparam int             WDW      = clog2_f(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_MAX = WDW'(WDOG_CYCLES);
    localparam logic [WDW-1:0] WDOG_ONE = WDW'(1);

    logic [WDW-1:0] wdog_q;
    logic [WDW-1:0] wdog_d;
    logic           wdog_err_q;
    logic           stall_s;

    // A stall is an owner that has started a word but is not presenting data.
    assign stall_s = (state_q == ST_BURST) && (cnt_q != '0) && !req_valid[grant_id_q];

    // Stall counter next state: clear on progress, saturate at the limit.
    always_comb begin
        wdog_d = wdog_q;
        if (xfer_s) begin
            wdog_d = '0;
        end else if (stall_s && (wdog_q != WDOG_MAX)) begin
            wdog_d = wdog_q + WDOG_ONE;
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Stall counter and sticky error flag; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_q | (wdog_d == WDOG_MAX);
        end
    end

    assign wdog_err = wdog_err_q;
`else
    // No watchdog in this build; the limit parameter stays on the interface so
    // both builds share one instantiation, and the flag folds to constant 0.
    assign wdog_err = (WDOG_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_deser_word_arbiter.sv
// Self-checking bench for deser_word_arbiter: a transaction-level model of
// ownership (owner, beats done, last winner) predicts every output each cycle,
// and directed scenarios pin the model with hand-computed beat sequences.
module tb_deser_word_arbiter;

    localparam int NREQ  = 4;
    localparam int INW   = 8;
    localparam int BEATS = 8;
`ifdef DESER_ARB_WDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [3:0]  req_ready;
    logic [31:0] req_data = 32'h0;
    logic        des_valid;
    logic        des_ready = 1'b0;
    logic [7:0]  des_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        wdog_err;

    deser_word_arbiter #(
        .NREQ        (NREQ),
        .INLOGBITS   (3),
        .OUTLOGBITS  (6),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .des_valid   (des_valid),
        .des_ready   (des_ready),
        .des_data    (des_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .wdog_err    (wdog_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;
    int m_done  = 0;
    int m_last  = NREQ - 1;
    int m_wd    = 0;
    bit m_err   = 1'b0;

    int mo, md, ml, mwd, mw;
    bit me, mxf;

    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        mo = m_owner; md = m_done; ml = m_last; mwd = m_wd; me = m_err;
        if (!rst_n) begin
            mo = -1; md = 0; ml = NREQ - 1; mwd = 0; me = 1'b0;
        end else begin
            mxf = (mo >= 0) && req_valid[mo] && des_ready;
            if (mxf) mwd = 0;
            else if (mo >= 0 && md != 0 && !req_valid[mo]) mwd = mwd + 1;
            if (mwd >= WD) me = 1'b1;
            if (mo < 0) begin
                mw = pick(req_valid, (ml + 1) % NREQ);
                if (mw >= 0) begin mo = mw; ml = mw; md = 0; end
            end else if (mxf) begin
                md = md + 1;
                if (md == BEATS) begin
                    md = 0;
                    mw = pick(req_valid, (mo + 1) % NREQ);
                    mo = mw;
                    if (mw >= 0) ml = mw;
                end
            end
        end
        m_owner <= mo; m_done <= md; m_last <= ml; m_wd <= mwd; m_err <= me;
    end

    // ---------------- per-cycle compare + transfer log ----------------
    bit chk_en = 1'b0;
    int log_id[$];
    int log_data[$];
    int xcnt[4] = '{0, 0, 0, 0};
    bit e_gv, e_dv;

    always @(negedge clk) begin
        if (chk_en) begin
            e_gv = (m_owner >= 0);
            e_dv = e_gv && req_valid[m_owner];
            chk("grant_valid", grant_valid, e_gv);
            chk("grant_id", grant_id, e_gv ? m_owner : 0);
            chk("des_valid", des_valid, e_dv);
            chk("req_ready", req_ready, (e_gv && des_ready) ? (32'd1 << m_owner) : 32'd0);
            if (e_dv) chk("des_data", des_data, req_data[m_owner*8 +: 8]);
`ifdef DESER_ARB_WDOG_EN
            chk("wdog_err", wdog_err, m_err);
`else
            chk("wdog_err", wdog_err, 0);
`endif
            if (des_valid && des_ready) begin
                log_id.push_back(grant_id);
                log_data.push_back(des_data);
                xcnt[grant_id] = xcnt[grant_id] + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int data_mode = 0;   // 0 random (driven by caller), 1 beat count, 2 id tag + beat count
    int base[4];
    int lb = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (data_mode != 0) begin
            for (int i = 0; i < NREQ; i++)
                req_data[i*8 +: 8] = 8'(((data_mode == 2) ? i * 16 : 0) + xcnt[i] - base[i]);
        end
    endtask

    task automatic phase_start();
        for (int i = 0; i < NREQ; i++) base[i] = xcnt[i];
        lb = log_id.size();
    endtask

    task automatic reset_phase(input int mode);
        phase_start();
        data_mode = mode;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input int limit, input string name);
        for (int t = 0; t < limit && (log_id.size() - lb) < n; t++) cyc();
        chk(name, (log_id.size() - lb) >= n, 1);
    endtask

    task automatic chk_log(input string name, input int idx, input int e_id, input int e_data);
        if (lb + idx < log_id.size()) begin
            chk({name, "_id"}, log_id[lb + idx], e_id);
            if (e_data >= 0) chk({name, "_data"}, log_data[lb + idx], e_data);
        end else begin
            chk({name, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state, all four requesting: 0,1,2,3,0 words, no bubbles.
        phase_start();
        req_valid = 4'b1111;
        des_ready = 1'b1;
        cyc();
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_des_valid", des_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wdog_err", wdog_err, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 41; c++) begin
            cyc();
            req_data = $urandom;
        end
        req_valid = 4'b0000;
        chk("rr_count", log_id.size() - lb, 40);
        for (int i = 0; i < 40; i++) chk_log("rr_order", i, (i / 8) % 4, -1);

        // Single requester 2: two back-to-back words, data 0x00..0x0F.
        req_valid = 4'b0000;
        reset_phase(1);
        req_valid = 4'b0100;
        wait_log(16, 60, "single_timeout");
        req_valid = 4'b0000;
        for (int i = 0; i < 16; i++) chk_log("single", i, 2, i);

        // Owner 1 drops valid after 3 beats while 0 waits.
        reset_phase(2);
        req_valid = 4'b0010;
        wait_log(3, 20, "drop_start_timeout");
        req_valid = 4'b0001;
        repeat (5) cyc();
        req_valid = 4'b0011;
        wait_log(9, 40, "drop_timeout");
        req_valid = 4'b0000;
        for (int i = 0; i < 8; i++) chk_log("drop", i, 1, 8'h10 + i);
        chk_log("drop_next", 8, 0, 8'h00);

        // Deserializer back-pressure for 10 cycles mid-word.
        reset_phase(2);
        req_valid = 4'b1000;
        wait_log(4, 20, "bp_start_timeout");
        des_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("bp_ready_low", req_ready, 0);
        end
        des_ready = 1'b1;
        wait_log(8, 30, "bp_timeout");
        req_valid = 4'b0000;
        for (int i = 0; i < 8; i++) chk_log("bp", i, 3, 8'h30 + i);
        chk("bp_count", log_id.size() - lb, 8);

        // Reset in the middle of a word: partial word dropped, req 0 first.
        reset_phase(2);
        req_valid = 4'b0010;
        wait_log(5, 20, "mrst_start_timeout");
        rst_n = 1'b0;
        req_valid = 4'b0011;
        cyc();
        chk("mrst_grant_valid", grant_valid, 0);
        chk("mrst_des_valid", des_valid, 0);
        rst_n = 1'b1;
        phase_start();
        wait_log(1, 10, "mrst_timeout");
        chk_log("mrst_first", 0, 0, 8'h00);
        req_valid = 4'b0000;

        // Owner stalls mid-word for 20 cycles, then finishes the word.
        reset_phase(2);
        req_valid = 4'b0001;
        wait_log(2, 20, "wd_start_timeout");
        req_valid = 4'b0000;
        repeat (20) cyc();
        req_valid = 4'b0001;
        wait_log(8, 30, "wd_timeout");
        req_valid = 4'b0000;
        repeat (3) cyc();
`ifdef DESER_ARB_WDOG_EN
        chk("wd_sticky", wdog_err, 1);
`else
        chk("wd_sticky", wdog_err, 0);
`endif

        // Randomized traffic with back-pressure and occasional resets.
        data_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            req_valid = 4'($urandom);
            des_ready = ($urandom_range(3) != 0);
            req_data  = $urandom;
            rst_n     = ($urandom_range(199) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/deser_word_arbiter.md
DESER_WORD_ARBITER -- requirements
Module: deser_word_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte-stream requesters sharing one deserializer (2..16).
REQ-002 Parameter INLOGBITS, default 3, log2 of the beat width INWIDTH.
REQ-003 Parameter OUTLOGBITS, default 6, log2 of the deserializer word width; BEATS = 1<<(OUTLOGBITS-INLOGBITS) beats per word.
REQ-004 Parameter WDOG_CYCLES, default 256, stall limit used only under DESER_ARB_WDOG_EN.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  NREQ  per-requester beat valid.
REQ-008 req_ready  output  NREQ  per-requester beat accept.
REQ-009 req_data  input  NREQ*INWIDTH  requester i data at bits [i*INWIDTH +: INWIDTH].
REQ-010 des_valid  output  1  beat valid toward deserializer.
REQ-011 des_ready  input  1  deserializer accept.
REQ-012 des_data  output  INWIDTH  beat data toward deserializer.
REQ-013 grant_valid  output  1  a requester currently owns the deserializer.
REQ-014 grant_id  output  clog2(NREQ)  owning requester index; 0 when grant_valid=0.
REQ-015 wdog_err  output  1  sticky stall error flag.

Function
REQ-016 States: IDLE (no owner) and BURST (owner grant_id, beat counter cnt of width OUTLOGBITS-INLOGBITS).
REQ-017 Beat transfer occurs when des_valid && des_ready; combinational path, zero-cycle latency.
REQ-018 In BURST: des_valid = req_valid[grant_id]; des_data = req_data slice grant_id; req_ready[grant_id] = des_ready; all other req_ready = 0.
REQ-019 In IDLE: des_valid = 0, all req_ready = 0.
REQ-020 Arbitration: round-robin, search starts at last_id+1 mod NREQ, first set req_valid wins.
REQ-021 IDLE -> BURST next cycle when any req_valid is set; grant_id, last_id <= winner; cnt <= 0.
REQ-022 In BURST each transfer increments cnt; grant held for exactly BEATS transfers (word atomicity), regardless of other requests.
REQ-023 On transfer with cnt == BEATS-1: cnt wraps to 0; re-arbitrate same cycle over current req_valid with owner lowest priority; a winner starts a BURST next cycle with no bubble, otherwise IDLE.
REQ-024 Owner dropping req_valid mid-word does not release grant; BURST waits.
REQ-025 des_ready low freezes cnt and grant.
REQ-026 Simultaneous requests: only the winner sees req_ready; losers hold their data.

Reset
REQ-027 While rst_n=0 at a clock edge: state IDLE, cnt 0, grant_valid 0, grant_id 0, last_id NREQ-1 (requester 0 first priority), wdog_err 0, watchdog counter 0.
REQ-028 Reset mid-BURST abandons the partial word; outputs reach reset values the cycle after the reset edge.

Configuration
REQ-029 Macro DESER_ARB_WDOG_EN defined: counter counts BURST cycles with cnt != 0 and req_valid[grant_id]=0, clears on any transfer; reaching WDOG_CYCLES sets wdog_err, held until reset; grant unaffected.
REQ-030 DESER_ARB_WDOG_EN undefined: no watchdog logic; wdog_err tied 0.

Structure
REQ-031 Shared package holds the IDLE/BURST state encoding and a clog2 helper constant function.
REQ-032 One sub-module rr_pick: combinational round-robin priority picker (request vector, start index -> winner index, found); instantiated once.
REQ-033 No deserializer instantiated inside; block sits directly upstream of one deserializer.

Verification
REQ-034 Reset, NREQ=4, req_valid=4'b1111, des_ready=1 -> grants 0,1,2,3,0 each exactly 8 consecutive transfers, no idle cycles between words.
REQ-035 Only req 2 valid, data 0x00..0x0F, des_ready=1 -> two back-to-back words of 8 beats, des_data in order, grant_id 2 throughout.
REQ-036 Owner req 1 drops valid after beat 3 for 5 cycles while req 0 valid -> grant stays 1, cnt holds 3, word completes, then req 0 granted.
REQ-037 des_ready low 10 cycles mid-word -> no req_ready, cnt/grant frozen, resume with no beat lost or duplicated.
REQ-038 rst_n low at beat 5 of a word -> next cycle grant_valid 0, des_valid 0; after release req 0 wins first if valid.
REQ-039 With DESER_ARB_WDOG_EN, WDOG_CYCLES=16, owner stalls mid-word 16 cycles -> wdog_err 1 and stays 1 after word completes until reset; without macro, wdog_err stays 0.
